// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the 5-stage pipeline: drives PC and pipeline-latch
// write enables and bubble flushes from stall, hazard, redirect and HALT inputs.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int FL_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_MemRead,
    input  logic [2:0]       IDEX_WriteRegister,
    input  logic [2:0]       IFID_Rs,
    input  logic [2:0]       IFID_Rt,
    input  logic             IFID_RsValid,
    input  logic             IFID_RtValid,
    input  logic             EXMEM_BranchingOrJumping,
    input  logic             EXMEM_Halt,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             PC_en,
    output logic             IFID_en,
    output logic             IDEX_en,
    output logic             EXMEM_en,
    output logic             MEMWB_en,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic [1:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [FL_W-1:0]  redirect_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ISTALL = 2'd1,
        DSTALL = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t curState, nextState;
    logic   redirectPending, nextPending;
    logic   countStall, countRedirect;
    logic   loadUse;

    assign loadUse = IDEX_MemRead &
                     ((IFID_RsValid & (IFID_Rs == IDEX_WriteRegister)) |
                      (IFID_RtValid & (IFID_Rt == IDEX_WriteRegister)));

    // Control contract: a latch captures on a rising edge when its en is 1;
    // flush=1 makes it capture a zero-control bubble, so flush implies en.
    always_comb begin
        PC_en         = 1'b0;
        IFID_en       = 1'b0;
        IDEX_en       = 1'b0;
        EXMEM_en      = 1'b0;
        MEMWB_en      = 1'b0;
        IFID_flush    = 1'b0;
        IDEX_flush    = 1'b0;
        EXMEM_flush   = 1'b0;
        nextState     = curState;
        nextPending   = redirectPending;
        countStall    = 1'b0;
        countRedirect = 1'b0;
        if (!rst || curState == HALT) begin
            // everything held off
        end else if (EXMEM_Halt && !dmem_stall) begin
            IFID_en     = 1'b1;
            IDEX_en     = 1'b1;
            EXMEM_en    = 1'b1;
            MEMWB_en    = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
            nextState   = HALT;
        end else if (dmem_stall) begin
            countStall = 1'b1;
            nextState  = DSTALL;
        end else if (EXMEM_BranchingOrJumping) begin
            PC_en         = 1'b1;
            IFID_en       = 1'b1;
            IDEX_en       = 1'b1;
            EXMEM_en      = 1'b1;
            MEMWB_en      = 1'b1;
            IFID_flush    = 1'b1;
            IDEX_flush    = 1'b1;
            EXMEM_flush   = 1'b1;
            countRedirect = 1'b1;
            // An in-flight fetch will return a wrong-path word; remember to drop it.
            nextPending   = imem_stall;
            nextState     = imem_stall ? ISTALL : RUN;
        end else if (imem_stall || loadUse) begin
            IDEX_en    = 1'b1;
            IDEX_flush = 1'b1;
            EXMEM_en   = 1'b1;
            MEMWB_en   = 1'b1;
            countStall = 1'b1;
            nextState  = imem_stall ? ISTALL : RUN;
        end else begin
            PC_en       = 1'b1;
            IFID_en     = 1'b1;
            IDEX_en     = 1'b1;
            EXMEM_en    = 1'b1;
            MEMWB_en    = 1'b1;
            IFID_flush  = redirectPending;
            nextPending = 1'b0;
            nextState   = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            curState        <= RUN;
            redirectPending <= 1'b0;
            stall_cycles    <= '0;
            redirect_count  <= '0;
        end else begin
            curState        <= nextState;
            redirectPending <= nextPending;
            if (countStall && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (countRedirect && redirect_count != '1)
                redirect_count <= redirect_count + FL_W'(1);
        end
    end

    assign state  = curState;
    assign halted = rst && (curState == HALT);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W = 6;
    localparam int FL_W  = 8;

    // control vector order: PC,IFID,IDEX,EXMEM,MEMWB en ; IFID,IDEX,EXMEM flush
    localparam logic [7:0] C_ALL    = 8'b11111_000;
    localparam logic [7:0] C_FREEZE = 8'b00000_000;
    localparam logic [7:0] C_BRANCH = 8'b11111_111;
    localparam logic [7:0] C_HALT   = 8'b01111_111;
    localparam logic [7:0] C_BUBBLE = 8'b00111_010;
    localparam logic [7:0] C_PENDFL = 8'b11111_100;

    logic clk = 1'b0;
    logic rst;
    logic IDEX_MemRead;
    logic [2:0] IDEX_WriteRegister, IFID_Rs, IFID_Rt;
    logic IFID_RsValid, IFID_RtValid;
    logic EXMEM_BranchingOrJumping, EXMEM_Halt, imem_stall, dmem_stall;
    logic PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
    logic IFID_flush, IDEX_flush, EXMEM_flush;
    logic [1:0] state;
    logic halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [FL_W-1:0]  redirect_count;
    logic [7:0] ctl;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    assign ctl = {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_flush, IDEX_flush, EXMEM_flush};

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .FL_W(FL_W)) dut (
        .clk(clk), .rst(rst),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_WriteRegister(IDEX_WriteRegister),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
        .IFID_RsValid(IFID_RsValid), .IFID_RtValid(IFID_RtValid),
        .EXMEM_BranchingOrJumping(EXMEM_BranchingOrJumping), .EXMEM_Halt(EXMEM_Halt),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush),
        .state(state), .halted(halted),
        .stall_cycles(stall_cycles), .redirect_count(redirect_count)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_idle();
        rst = 1'b1;
        IDEX_MemRead = 1'b0;
        IDEX_WriteRegister = 3'd0;
        IFID_Rs = 3'd1;
        IFID_Rt = 3'd2;
        IFID_RsValid = 1'b1;
        IFID_RtValid = 1'b1;
        EXMEM_BranchingOrJumping = 1'b0;
        EXMEM_Halt = 1'b0;
        imem_stall = 1'b0;
        dmem_stall = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        advance();
        advance();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b0;
        EXMEM_BranchingOrJumping = 1'b1;
        imem_stall = 1'b1;
        advance();
        advance();
        settle();
        checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_FREEZE); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (stall_cycles !== '0 || redirect_count !== '0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, redirect_count); end
        advance();
        set_idle();
        settle();
        checks++; if (ctl !== C_ALL) begin errors++; $display("FAIL reset_run_ctl: got %b expected %b", ctl, C_ALL); end
        advance();
    endtask

    task automatic test_load_use();
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 3'd3;
        IFID_Rs = 3'd3; IFID_RsValid = 1'b1; IFID_Rt = 3'd5; IFID_RtValid = 1'b1;
        settle();
        checks++; if (ctl !== C_BUBBLE) begin errors++; $display("FAIL load_use_ctl: got %b expected %b", ctl, C_BUBBLE); end
        advance();
        set_idle();
        settle();
        checks++; if (ctl !== C_ALL) begin errors++; $display("FAIL load_use_after_ctl: got %b expected %b", ctl, C_ALL); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL load_use_state: got %0d expected 0", state); end
        checks++; if (stall_cycles !== CNT_W'(1)) begin errors++; $display("FAIL load_use_stalls: got %0d expected 1", stall_cycles); end
        advance();
        // hazard through Rt only
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 3'd6;
        IFID_Rs = 3'd1; IFID_Rt = 3'd6; IFID_RtValid = 1'b1;
        settle();
        checks++; if (ctl !== C_BUBBLE) begin errors++; $display("FAIL load_use_rt_ctl: got %b expected %b", ctl, C_BUBBLE); end
        advance();
        set_idle();
    endtask

    task automatic test_invalid_src();
        do_reset();
        IDEX_MemRead = 1'b1; IDEX_WriteRegister = 3'd3;
        IFID_Rs = 3'd3; IFID_RsValid = 1'b0; IFID_Rt = 3'd3; IFID_RtValid = 1'b0;
        settle();
        checks++; if (ctl !== C_ALL) begin errors++; $display("FAIL invalid_src_ctl: got %b expected %b", ctl, C_ALL); end
        IDEX_MemRead = 1'b0; IFID_RsValid = 1'b1; IFID_RtValid = 1'b1;
        #1;
        checks++; if (ctl !== C_ALL) begin errors++; $display("FAIL no_load_ctl: got %b expected %b", ctl, C_ALL); end
        advance();
        set_idle();
        settle();
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL invalid_src_stalls: got %0d expected 0", stall_cycles); end
        advance();
    endtask

    task automatic test_branch();
        do_reset();
        EXMEM_BranchingOrJumping = 1'b1;
        settle();
        checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL branch_ctl: got %b expected %b", ctl, C_BRANCH); end
        advance();
        set_idle();
        settle();
        checks++; if (redirect_count !== FL_W'(1)) begin errors++; $display("FAIL branch_count: got %0d expected 1", redirect_count); end
        checks++; if (ctl !== C_ALL || state !== 2'd0) begin errors++; $display("FAIL branch_after: got %b/%0d expected %b/0", ctl, state, C_ALL); end
        advance();
    endtask

    task automatic test_branch_istall();
        do_reset();
        EXMEM_BranchingOrJumping = 1'b1; imem_stall = 1'b1;
        settle();
        checks++; if (ctl !== C_BRANCH) begin errors++; $display("FAIL br_is_ctl: got %b expected %b", ctl, C_BRANCH); end
        advance();
        EXMEM_BranchingOrJumping = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++; if (state !== 2'd1 || ctl !== C_BUBBLE) begin errors++; $display("FAIL br_is_stall%0d: got %0d/%b expected 1/%b", i, state, ctl, C_BUBBLE); end
            advance();
        end
        imem_stall = 1'b0;
        settle();
        checks++; if (ctl !== C_PENDFL) begin errors++; $display("FAIL br_is_pendflush: got %b expected %b", ctl, C_PENDFL); end
        advance();
        settle();
        checks++; if (ctl !== C_ALL || state !== 2'd0) begin errors++; $display("FAIL br_is_cleared: got %b/%0d expected %b/0", ctl, state, C_ALL); end
        checks++; if (stall_cycles !== CNT_W'(2) || redirect_count !== FL_W'(1)) begin errors++; $display("FAIL br_is_counters: got %0d/%0d expected 2/1", stall_cycles, redirect_count); end
        advance();
    endtask

    task automatic test_dstall();
        do_reset();
        dmem_stall = 1'b1; imem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL dstall_ctl%0d: got %b expected %b", i, ctl, C_FREEZE); end
            advance();
        end
        dmem_stall = 1'b0;
        settle();
        checks++; if (state !== 2'd2 || stall_cycles !== CNT_W'(4)) begin errors++; $display("FAIL dstall_state: got %0d/%0d expected 2/4", state, stall_cycles); end
        checks++; if (ctl !== C_BUBBLE) begin errors++; $display("FAIL dstall_exit_ctl: got %b expected %b", ctl, C_BUBBLE); end
        advance();
        imem_stall = 1'b0;
        settle();
        checks++; if (state !== 2'd1 || ctl !== C_ALL) begin errors++; $display("FAIL dstall_to_istall: got %0d/%b expected 1/%b", state, ctl, C_ALL); end
        advance();
        // pending redirect survives a data stall
        EXMEM_BranchingOrJumping = 1'b1; imem_stall = 1'b1;
        advance();
        EXMEM_BranchingOrJumping = 1'b0; dmem_stall = 1'b1;
        advance();
        advance();
        dmem_stall = 1'b0; imem_stall = 1'b0;
        settle();
        checks++; if (ctl !== C_PENDFL) begin errors++; $display("FAIL dstall_pending: got %b expected %b", ctl, C_PENDFL); end
        advance();
        set_idle();
    endtask

    task automatic test_halt();
        do_reset();
        EXMEM_Halt = 1'b1; dmem_stall = 1'b1;
        settle();
        checks++; if (ctl !== C_FREEZE) begin errors++; $display("FAIL halt_dmem_ctl: got %b expected %b", ctl, C_FREEZE); end
        advance();
        dmem_stall = 1'b0;
        settle();
        checks++; if (ctl !== C_HALT || halted !== 1'b0) begin errors++; $display("FAIL halt_ctl: got %b/%b expected %b/0", ctl, halted, C_HALT); end
        advance();
        for (int i = 0; i < 4; i++) begin
            EXMEM_BranchingOrJumping = 1'($urandom_range(0, 1));
            imem_stall = 1'($urandom_range(0, 1));
            settle();
            checks++; if (ctl !== C_FREEZE || halted !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL halted%0d: got %b/%b/%0d expected %b/1/3", i, ctl, halted, state, C_FREEZE); end
            advance();
        end
        settle();
        checks++; if (stall_cycles !== CNT_W'(1) || redirect_count !== '0) begin errors++; $display("FAIL halt_counters: got %0d/%0d expected 1/0", stall_cycles, redirect_count); end
        rst = 1'b0;
        #1;
        checks++; if (halted !== 1'b0 || ctl !== C_FREEZE) begin errors++; $display("FAIL halt_rst_low: got %b/%b expected 0/%b", halted, ctl, C_FREEZE); end
        advance();
        set_idle();
        settle();
        checks++; if (state !== 2'd0 || ctl !== C_ALL) begin errors++; $display("FAIL halt_release: got %0d/%b expected 0/%b", state, ctl, C_ALL); end
        checks++; if (stall_cycles !== '0 || redirect_count !== '0) begin errors++; $display("FAIL halt_rst_counters: got %0d/%0d expected 0/0", stall_cycles, redirect_count); end
        advance();
    endtask

    task automatic test_saturation();
        do_reset();
        EXMEM_BranchingOrJumping = 1'b1;
        for (int i = 0; i < 260; i++) advance();
        EXMEM_BranchingOrJumping = 1'b0;
        dmem_stall = 1'b1;
        for (int i = 0; i < 70; i++) advance();
        dmem_stall = 1'b0;
        settle();
        checks++; if (redirect_count !== 8'd255) begin errors++; $display("FAIL redirect_sat: got %0d expected 255", redirect_count); end
        checks++; if (stall_cycles !== 6'd63) begin errors++; $display("FAIL stall_sat: got %0d expected 63", stall_cycles); end
        advance();
    endtask

    // randomized run against a rule-level model (mode: 0 run,1 istall,2 dstall,3 halt)
    task automatic test_random();
        int mode, pending, stallN, redirN;
        logic [7:0] readMask, expCtl, gotCtl;
        bit lu;
        do_reset();
        mode = 0; pending = 0; stallN = 0; redirN = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 59) != 0);
            IDEX_MemRead = ($urandom_range(0, 2) == 0);
            IDEX_WriteRegister = 3'($urandom_range(0, 7));
            IFID_Rs = 3'($urandom_range(0, 7));
            IFID_Rt = 3'($urandom_range(0, 7));
            IFID_RsValid = 1'($urandom_range(0, 1));
            IFID_RtValid = 1'($urandom_range(0, 1));
            EXMEM_BranchingOrJumping = ($urandom_range(0, 5) == 0);
            EXMEM_Halt = ($urandom_range(0, 79) == 0);
            imem_stall = ($urandom_range(0, 3) == 0);
            dmem_stall = ($urandom_range(0, 5) == 0);

            readMask = 8'd0;
            if (IFID_RsValid) readMask = readMask | (8'd1 << IFID_Rs);
            if (IFID_RtValid) readMask = readMask | (8'd1 << IFID_Rt);
            lu = IDEX_MemRead && readMask[IDEX_WriteRegister];

            if (!rst || mode == 3) expCtl = C_FREEZE;
            else if (EXMEM_Halt && !dmem_stall) expCtl = C_HALT;
            else if (dmem_stall) expCtl = C_FREEZE;
            else if (EXMEM_BranchingOrJumping) expCtl = C_BRANCH;
            else if (imem_stall || lu) expCtl = C_BUBBLE;
            else expCtl = (pending != 0) ? C_PENDFL : C_ALL;
            exp_q.push_back(expCtl);

            settle();
            gotCtl = ctl;
            expCtl = exp_q.pop_front();
            checks++; if (gotCtl !== expCtl) begin errors++; $display("FAIL rand_ctl@%0d: got %b expected %b", cyc, gotCtl, expCtl); end
            checks++; if (state !== 2'(mode)) begin errors++; $display("FAIL rand_state@%0d: got %0d expected %0d", cyc, state, mode); end
            checks++; if (halted !== (rst && mode == 3)) begin errors++; $display("FAIL rand_halted@%0d: got %b expected %b", cyc, halted, (rst && mode == 3)); end
            checks++; if (stall_cycles !== CNT_W'(stallN) || redirect_count !== FL_W'(redirN)) begin errors++; $display("FAIL rand_counters@%0d: got %0d/%0d expected %0d/%0d", cyc, stall_cycles, redirect_count, stallN, redirN); end

            if (!rst) begin
                mode = 0; pending = 0; stallN = 0; redirN = 0;
            end else if (mode != 3) begin
                if (EXMEM_Halt && !dmem_stall) mode = 3;
                else if (dmem_stall) begin mode = 2; stallN++; end
                else if (EXMEM_BranchingOrJumping) begin
                    redirN++;
                    pending = imem_stall ? 1 : 0;
                    mode = imem_stall ? 1 : 0;
                end
                else if (imem_stall) begin mode = 1; stallN++; end
                else if (lu) begin mode = 0; stallN++; end
                else begin mode = 0; pending = 0; end
                if (stallN > 63) stallN = 63;
                if (redirN > 255) redirN = 255;
            end
            advance();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_invalid_src();
        test_branch();
        test_branch_istall();
        test_dstall();
        test_halt();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage core. It drives the write-enable and flush (bubble) controls of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It resolves instruction-memory stalls, data-memory stalls, load-use hazards, taken branch/jump redirects resolved in MEM, and HALT. It sits beside the datapath, takes decoded hazard information from the latch outputs, and holds the only sequencing state in the pipeline.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter
- FL_W, 8, width of the redirect counter

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-low
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_WriteRegister  in  3  destination of instruction in EX
- IFID_Rs, IFID_Rt  in  3 each  source registers of instruction in ID
- IFID_RsValid, IFID_RtValid  in  1 each  the source is actually read
- EXMEM_BranchingOrJumping  in  1  taken branch/jump resolved in MEM
- EXMEM_Halt  in  1  HALT instruction in MEM
- imem_stall  in  1  level; instruction fetch not yet complete
- dmem_stall  in  1  level; data access in MEM not yet complete
- PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en  out  1 each  latch write enables
- IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  latch loads a bubble (zero control); the matching en is always 1 when flush is 1
- state  out  2  RUN=0, ISTALL=1, DSTALL=2, HALT=3
- halted  out  1  1 iff state==HALT
- stall_cycles  out  CNT_W  saturating count of cycles with PC_en=0 outside HALT
- redirect_count  out  FL_W  saturating count of taken redirects

## Operation
- Registers: state, redirect_pending, stall_cycles, redirect_count. All other outputs are combinational from the registers and the current inputs.
- load_use = IDEX_MemRead & ((IFID_RsValid & IFID_Rs==IDEX_WriteRegister) | (IFID_RtValid & IFID_Rt==IDEX_WriteRegister)).
- In state HALT: all enables 0, all flushes 0, halted=1. The block stays in HALT until reset.
- Outside HALT, the first matching rule applies each cycle:
  1. EXMEM_Halt & !dmem_stall: PC_en=0, IFID_flush=IDEX_flush=EXMEM_flush=1, MEMWB_en=1 (the HALT reaches WB). Next state HALT.
  2. dmem_stall: all enables 0, all flushes 0 (full freeze). Next state DSTALL.
  3. EXMEM_BranchingOrJumping: PC_en=1 (loads target), IFID/IDEX/EXMEM flush=1, MEMWB_en=1, redirect_count+1. If imem_stall is also 1: set redirect_pending and go to ISTALL. Otherwise go to RUN.
  4. imem_stall: PC_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=MEMWB_en=1. Next state ISTALL.
  5. load_use: PC_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=MEMWB_en=1. Next state RUN.
  6. Otherwise: all enables 1, no flush. If redirect_pending=1, then IFID_flush=1 (the completed fetch is wrong-path) and redirect_pending clears. Next state RUN.
- stall_cycles increments when PC_en=0 and state!=HALT, and does not increment on the rule-1 cycle. It saturates at all-ones. redirect_count also saturates.

## Timing
- While rst=0 at a clk edge: state←RUN, redirect_pending←0, both counters←0. While rst is low, all enables and flushes are 0 and halted=0.
- Enables and flushes are valid in the same cycle as their inputs. The latches act on them at the next rising edge.
- Load-use costs exactly 1 bubble. A redirect costs 3 squashed slots, plus 1 more if the fetch was in flight (redirect_pending).
- Leaving DSTALL and ISTALL happens in the first cycle the stall input is low. That cycle is evaluated with the normal rules; there is no extra dead cycle.
- When imem_stall and dmem_stall are both high, dmem_stall wins. redirect_pending is held across DSTALL.
- A reset asserted mid-stall or in HALT takes effect at the next edge.

## Test plan
- Load-use: LD into R3 in EX while ID reads Rs=R3 (valid) -> exactly one cycle with PC_en=0, IFID_en=0, IDEX_flush=1, state stays RUN. The next cycle has all enables at 1, and stall_cycles=1.
- Invalid source: same as above but IFID_RsValid=0 -> no stall.
- Taken branch: EXMEM_BranchingOrJumping=1 for 1 cycle -> IFID/IDEX/EXMEM flush=1, PC_en=1, redirect_count=1.
- Taken branch with imem_stall=1, and imem_stall held 2 more cycles -> state goes to ISTALL. On the first cycle with imem_stall=0, IFID_flush=1, then redirect_pending clears.
- dmem_stall held 4 cycles overlapping imem_stall -> every enable is 0 for 4 cycles, state=DSTALL, stall_cycles=4. The following cycle returns to RUN or ISTALL per imem_stall.
- HALT in MEM -> one cycle with MEMWB_en=1, PC_en=0 and all three flushes at 1, then halted=1 with enables at 0 indefinitely. Pulsing rst=0 for 1 cycle returns the block to RUN with both counters at 0.
